mem_router_arb: RTL

- Parametrised successor to the fixed-map main memory. Arbitrates a CPU and a PPU requester onto one memory fabric.
- Requests are routed by an address tag to two internal dual-region RAMs (CPU-RAM, VRAM) or to an external cart port with a stallable handshake.
- Read data is registered and returned per requester with a valid pulse.
- Sits between the NES core and cart_mem so that slow cart storage (SPI/QSPI-backed) can stall the core cleanly.

---
 rtl/mem_router_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_router_arb.sv
// Two-requester (CPU/PPU) memory router: arbitrates one grant at a time and routes it by
// address tag to internal CPU-RAM, internal VRAM, or a stallable external cart port.
module mem_router_arb #(
  parameter int         ADDR_W     = 22,
  parameter int         DATA_W     = 8,
  parameter int         RAM_AW     = 11,
  parameter logic [3:0] CPURAM_TAG = 4'b1110,
  parameter logic [3:0] VRAM_TAG   = 4'b1100,
  parameter bit         RR_ARB     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ppu_req,
  input  logic              ppu_we,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic [DATA_W-1:0] ppu_wdata,
  output logic              ppu_ack,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  output logic              cart_req,
  output logic              cart_we,
  output logic [ADDR_W-1:0] cart_addr,
  output logic [DATA_W-1:0] cart_wdata,
  input  logic              cart_ack,
  input  logic [DATA_W-1:0] cart_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, INT_RD = 2'd1, CART_WAIT = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic                grant, grant_ppu, rd_done;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [3:0]          win_tag;
  logic [1:0]          win_hit, ram_we, ram_re;
  logic                prefer_ppu_reg;
  logic                lat_id_reg, lat_we_reg, lat_vram_reg, cart_req_reg;
  logic [ADDR_W-1:0]   lat_addr_reg;
  logic [DATA_W-1:0]   lat_wdata_reg;
  logic [DATA_W-1:0]   rd_data;

  // Round-robin favours whoever lost the previous grant; fixed mode always favours the PPU.
  always_comb begin
    grant_ppu = ppu_req;
    if (RR_ARB)
      grant_ppu = ppu_req & (~cpu_req | prefer_ppu_reg);
  end

  assign win_we    = grant_ppu ? ppu_we    : cpu_we;
  assign win_addr  = grant_ppu ? ppu_addr  : cpu_addr;
  assign win_wdata = grant_ppu ? ppu_wdata : cpu_wdata;
  assign win_tag   = win_addr[ADDR_W-1 -: 4];

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          if (|win_hit) state_next = win_we ? IDLE : INT_RD;
          else          state_next = CART_WAIT;
        end
      end
      INT_RD:    state_next = IDLE;
      CART_WAIT: if (cart_ack) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM: outputs (ack is combinational so it lands in the grant cycle; masked during reset)
  always_comb begin
    grant   = 1'b0;
    busy    = 1'b1;
    rd_done = 1'b0;
    case (state_reg)
      IDLE: begin
        busy  = 1'b0;
        grant = reset_n & (cpu_req | ppu_req);
      end
      INT_RD:    rd_done = 1'b1;
      CART_WAIT: rd_done = cart_ack & ~lat_we_reg;
      default:   ;
    endcase
  end

  assign cpu_ack = grant & ~grant_ppu;
  assign ppu_ack = grant &  grant_ppu;
  assign ram_we  = {2{grant &  win_we}} & win_hit;
  assign ram_re  = {2{grant & ~win_we}} & win_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prefer_ppu_reg <= 1'b0;
      lat_id_reg     <= 1'b0;
      lat_we_reg     <= 1'b0;
      lat_vram_reg   <= 1'b0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
      cart_req_reg   <= 1'b0;
    end else begin
      if (grant) begin
        prefer_ppu_reg <= ~grant_ppu;
        lat_id_reg     <= grant_ppu;
        lat_we_reg     <= win_we;
        lat_vram_reg   <= win_hit[1];
        lat_addr_reg   <= win_addr;
        lat_wdata_reg  <= win_wdata;
      end
      if (grant && !(|win_hit))
        cart_req_reg <= 1'b1;
      else if (state_reg == CART_WAIT && cart_ack)
        cart_req_reg <= 1'b0;
    end
  end

  assign cart_req   = cart_req_reg;
  assign cart_we    = lat_we_reg;
  assign cart_addr  = lat_addr_reg;
  assign cart_wdata = lat_wdata_reg;

  // Index 0 is CPU-RAM, index 1 is VRAM; contents are never reset.
  for (genvar gi = 0; gi < 2; gi++) begin : ram_gen
    localparam logic [3:0] TAG = (gi == 0) ? CPURAM_TAG : VRAM_TAG;
    logic [DATA_W-1:0] mem [2**RAM_AW];
    logic [DATA_W-1:0] rd_q;

    assign win_hit[gi] = (win_tag == TAG);

    always_ff @(posedge clock) begin
      if (ram_we[gi]) mem[win_addr[RAM_AW-1:0]] <= win_wdata;
      if (ram_re[gi]) rd_q <= mem[win_addr[RAM_AW-1:0]];
    end
  end

  assign rd_data = (state_reg == INT_RD) ? (lat_vram_reg ? ram_gen[1].rd_q : ram_gen[0].rd_q)
                                         : cart_rdata;

  // Index 0 is the CPU return path, index 1 the PPU.
  for (genvar gi = 0; gi < 2; gi++) begin : ret_gen
    localparam logic ID = (gi == 1);
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_done && (lat_id_reg == ID);
        if (rd_done && (lat_id_reg == ID))
          rdata_q <= rd_data;
      end
    end
  end

  assign cpu_rvalid = ret_gen[0].rvalid_q;
  assign cpu_rdata  = ret_gen[0].rdata_q;
  assign ppu_rvalid = ret_gen[1].rvalid_q;
  assign ppu_rdata  = ret_gen[1].rdata_q;

endmodule
